clock_divider_prog: RTL
=======================

# clock_divider_prog

Multi-channel, runtime-programmable clock divider; the parametrised successor to the fixed 1 Hz-style divider. It derives CH independent slow square waves plus one-cycle tick strobes from the board clock. Each channel has its own period and high-time, loadable at run time through a valid/ready config port. It sits between the 50 MHz board clock and the scheduler/display logic that consumes slow clocks or enables.

## Interface
- CH, 2, number of independent output channels (1..16)
- W, 32, counter, divisor and high-time width
- DEFAULT_DIV, 37000000, reset period in cin cycles for every channel (must be ≥2)
- DEFAULT_HIGH, DEFAULT_DIV/2, reset high-time in cin cycles for every channel
- cin  in  1  clock; single clock domain; all logic on posedge cin
- rst  in  1  reset; synchronous, active-high
- en  in  CH  per-channel run enable
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accept; transfer when cfg_valid && cfg_ready
- cfg_ch  in  max(1,$clog2(CH))  target channel
- cfg_div  in  W  new period in cin cycles
- cfg_high  in  W  new high-time in cin cycles
- cfg_err  out  1  one-cycle pulse: accepted request rejected (bad div or channel)
- cout  out  CH  divided clock per channel, registered
- tick  out  CH  one-cycle strobe per channel at period wrap, registered

## Operation
- Per channel i: count[i] (W bits), div[i], high[i], registered cout[i]/tick[i].
- en[i]=1, each cycle: wrap = (count==div-1); count_next = wrap ? 0 : count+1; cout <= (count_next >= div-high); tick <= wrap.
- Low phase first, then high phase (div-high low cycles, then high cycles).
- high==0: cout constantly 0. high ≥ div: cout constantly 1. Subtraction div-high saturates at 0; no wrap-around.
- en[i]=0: count forced to 0, cout 0, tick 0 next cycle; div/high retained. Re-assert restarts a full period from count 0.
- Config accept: cfg_div<2 or cfg_ch≥CH → request consumed, no state change, cfg_err=1 next cycle.
- Valid request is staged (see Configuration). cfg_high is not checked; clamping rules above apply.
- Channels fully independent; no phase alignment between channels.

## Timing
- Reset values: count=0, div=DEFAULT_DIV, high=DEFAULT_HIGH, cout=0, tick=0, cfg_err=0, no pending loads, cfg_ready=1.
- rst mid-operation: all of the above on the next edge; pending loads discarded.
- Output latency: cout/tick reflect count_next of the same edge (registered, no combinational path from inputs).
- tick period = div cycles; tick coincides with the edge where count returns to 0 and cout falls (when 0<high<div).
- cfg_ready combinational from cfg_ch and pending state only; cfg_valid may be held until ready.
- Back-to-back accepts allowed every cycle to different channels.

## Configuration
- CLKDIV_BOUNDARY_LOAD_EN defined: accepted config written to pending registers of cfg_ch; applied on that channel's wrap edge (new div/high used for that edge's cout computation, count goes to 0). If en[i]=0 while pending, applied on the next edge. cfg_ready = ~pending[cfg_ch]. Glitch-free: no truncated period.
- Not defined: no pending registers; cfg_ready tied 1; accepted config applied on the next edge, count[cfg_ch] forced to 0, cout 0, tick 0 (current period truncated).

## Test plan
- Reset with DEFAULT_DIV=4, DEFAULT_HIGH=2, en=all 1 after rst → cout 0,0,1,1 repeating per channel; tick high every 4th cycle on the cout falling edge.
- Load ch0 div=5 high=1 mid-period (macro on) → current 4-cycle period completes, then cout 0,0,0,0,1 repeating; ch1 unchanged; cfg_ready low for ch0 until wrap.
- Same load with macro off → cfg_ready stays 1; next edge count=0, cout=0; new 5-cycle pattern from there.
- cfg_div=1 or cfg_ch=CH → cfg_err pulses one cycle, all channel outputs unchanged.
- high=0 → cout stuck 0, tick still every div; high=7 with div=5 → cout stuck 1.
- Deassert en[1] for 3 cycles then reassert; assert rst mid-period with pending load → en low gives cout[1]=tick[1]=0 and restart from count 0; rst restores defaults and drops pending load.

Source files
------------

// File: rtl/clock_divider_prog.sv
// -----------------------------------------------------------------------------
// clock_divider_prog
//
// Purpose:
//   Multi-channel runtime-programmable clock divider. Each of CH channels
//   produces a registered slow square wave (cout) and a one-cycle strobe at
//   every period wrap (tick). Each channel's period (div) and high-time (high)
//   are loaded through a valid/ready configuration port. In each period the
//   low phase comes first (div-high cycles), then the high phase.
//
// Ports:
//   cin        in   board clock, all logic on its rising edge
//   rst        in   synchronous active-high reset
//   en         in   [CH]  per-channel run enable (0 holds count at 0, outputs low)
//   cfg_valid  in   configuration request
//   cfg_ready  out  configuration accept (transfer on cfg_valid && cfg_ready)
//   cfg_ch     in   [CW]  target channel
//   cfg_div    in   [W]   new period in cin cycles (must be >= 2)
//   cfg_high   in   [W]   new high-time in cin cycles (0 = always low,
//                         >= div = always high)
//   cfg_err    out  one-cycle pulse: an accepted request was rejected
//   cout       out  [CH]  divided clock per channel, registered
//   tick       out  [CH]  wrap strobe per channel, registered
//
// Build option:
//   CLKDIV_BOUNDARY_LOAD_EN  when defined, accepted configs are held in a
//                            per-channel pending slot and applied on that
//                            channel's wrap edge (no truncated period), and
//                            cfg_ready drops while the target slot is full.
//                            When undefined, configs apply on the next edge
//                            and restart the channel from count 0.
// -----------------------------------------------------------------------------
module clock_divider_prog #(
    parameter int CH           = 2,
    parameter int W            = 32,
    parameter int DEFAULT_DIV  = 37000000,
    parameter int DEFAULT_HIGH = DEFAULT_DIV / 2,
    localparam int CW          = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          cin,
    input  logic          rst,
    input  logic [CH-1:0] en,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_ch,
    input  logic [W-1:0]  cfg_div,
    input  logic [W-1:0]  cfg_high,
    output logic          cfg_err,
    output logic [CH-1:0] cout,
    output logic [CH-1:0] tick
);

    localparam logic [W-1:0]  DIV_RST  = W'(DEFAULT_DIV);
    localparam logic [W-1:0]  HIGH_RST = W'(DEFAULT_HIGH);
    localparam logic [W-1:0]  ONE      = W'(1);
    localparam logic [W-1:0]  TWO      = W'(2);
    localparam logic [CW:0]   CH_LIM   = (CW + 1)'(CH);

    // Count value at which the high phase begins; div-high saturates at 0 so
    // that high >= div yields a constantly high output instead of wrapping.
    function automatic logic [W-1:0] high_start(input logic [W-1:0] d,
                                                input logic [W-1:0] h);
        return (h >= d) ? '0 : (d - h);
    endfunction

    logic cfg_bad;
    logic accept;

    // One extra MSB on the channel compare catches indices >= CH even when
    // CH is a power of two.
    assign cfg_bad = (cfg_div < TWO) || ({1'b0, cfg_ch} >= CH_LIM);
    assign accept  = cfg_valid && cfg_ready;

    always_ff @(posedge cin) begin
        // NOTE: sequential state is always assigned with <= so every register
        // samples the pre-edge values of its neighbours.
        if (rst) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept && cfg_bad;
        end
    end

`ifdef CLKDIV_BOUNDARY_LOAD_EN
    logic [CH-1:0] pend_vec;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        cfg_ready = 1'b1;
        for (int i = 0; i < CH; i++) begin
            if (cfg_ch == CW'(i)) begin
                cfg_ready = ~pend_vec[i];
            end
        end
    end
`else
    assign cfg_ready = 1'b1;
`endif

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [W-1:0] count_q;
        logic [W-1:0] div_q;
        logic [W-1:0] high_q;
        logic         cout_q;
        logic         tick_q;
        logic         sel;
        logic         wrap;
        logic [W-1:0] count_nxt;

        assign sel       = accept && !cfg_bad && (cfg_ch == CW'(i));
        assign wrap      = (count_q == (div_q - ONE));
        assign count_nxt = wrap ? '0 : (count_q + ONE);
        assign cout[i]   = cout_q;
        assign tick[i]   = tick_q;

`ifdef CLKDIV_BOUNDARY_LOAD_EN
        logic         pend_q;
        logic [W-1:0] pend_div_q;
        logic [W-1:0] pend_high_q;
        logic         apply;

        // A disabled channel has no period to protect, so it takes the
        // pending load immediately.
        assign apply       = pend_q && (!en[i] || wrap);
        assign pend_vec[i] = pend_q;

        // NOTE: the pending payload is qualified by pend_q, so it carries no
        // reset and is just a plain load-enabled register.
        always_ff @(posedge cin) begin
            if (sel) begin
                pend_div_q  <= cfg_div;
                pend_high_q <= cfg_high;
            end
        end

        always_ff @(posedge cin) begin
            if (rst) begin
                count_q <= '0;
                div_q   <= DIV_RST;
                high_q  <= HIGH_RST;
                cout_q  <= 1'b0;
                tick_q  <= 1'b0;
                pend_q  <= 1'b0;
            end else begin
                if (apply) begin
                    // The wrap edge already uses the new settings: count
                    // restarts at 0, so cout is high only if high >= div.
                    div_q   <= pend_div_q;
                    high_q  <= pend_high_q;
                    count_q <= '0;
                    cout_q  <= en[i] && (high_start(pend_div_q, pend_high_q) == '0);
                    tick_q  <= en[i];
                    pend_q  <= 1'b0;
                end else if (!en[i]) begin
                    count_q <= '0;
                    cout_q  <= 1'b0;
                    tick_q  <= 1'b0;
                end else begin
                    count_q <= count_nxt;
                    cout_q  <= (count_nxt >= high_start(div_q, high_q));
                    tick_q  <= wrap;
                end
                // sel needs cfg_ready, i.e. an empty slot, so it never
                // coincides with apply.
                if (sel) begin
                    pend_q <= 1'b1;
                end
            end
        end
`else
        always_ff @(posedge cin) begin
            if (rst) begin
                count_q <= '0;
                div_q   <= DIV_RST;
                high_q  <= HIGH_RST;
                cout_q  <= 1'b0;
                tick_q  <= 1'b0;
            end else if (sel) begin
                // Immediate load truncates the running period.
                div_q   <= cfg_div;
                high_q  <= cfg_high;
                count_q <= '0;
                cout_q  <= 1'b0;
                tick_q  <= 1'b0;
            end else if (!en[i]) begin
                count_q <= '0;
                cout_q  <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                count_q <= count_nxt;
                cout_q  <= (count_nxt >= high_start(div_q, high_q));
                tick_q  <= wrap;
            end
        end
`endif
    end

endmodule
